// File: rtl/decode_pkg.sv
// Shared instruction-field layout and decode helper for 32-bit instruction words.
package decode_pkg;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RDST_MSB  = 25;
  localparam int RDST_LSB  = 21;
  localparam int RS1_MSB   = 20;
  localparam int RS1_LSB   = 16;
  localparam int RS2_MSB   = 15;
  localparam int RS2_LSB   = 11;
  localparam int FUNCT_MSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rdst;
    logic [4:0]  rsrc1;
    logic [4:0]  rsrc2;
    logic [6:0]  funct;
    logic [15:0] imm;
  } dec_t;

  function automatic dec_t decode_fields(input logic [31:0] ir);
    dec_t d;
    d.opcode = ir[OPC_MSB:OPC_LSB];
    d.rdst   = ir[RDST_MSB:RDST_LSB];
    d.rsrc1  = ir[RS1_MSB:RS1_LSB];
    d.rsrc2  = ir[RS2_MSB:RS2_LSB];
    d.funct  = ir[FUNCT_MSB:FUNCT_LSB];
    d.imm    = ir[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_skid_buf.sv
// Two-entry valid/ready buffer (main + skid) holding raw words; o_ready is ~skid_full.
module skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_vld;
  logic         r_skid_vld;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_acc;
  logic         w_load;

  assign o_ready = ~r_skid_vld;
  assign o_valid = r_main_vld;
  assign o_data  = r_main;
  assign w_acc   = i_valid & ~r_skid_vld;
  assign w_load  = ~r_main_vld | i_ready;

  // Flush outranks every transfer; while the skid is full no new word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
    end else if (i_flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
    end else if (w_load) begin
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_main_vld <= w_acc;
        if (w_acc) r_main <= i_data;
      end
    end else if (w_acc) begin
      r_skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && r_main_vld && !i_ready) r_skid <= i_data;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with skid buffering. Define DECODE_SCOREBOARD_EN to add
// the RAW pending-register scoreboard and the wb_valid/wb_idx ports.
module decode_stage
  import decode_pkg::*;
#(
  parameter int IW     = 32,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     in_ir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rdst,
  output logic [4:0]        rsrc1,
  output logic [4:0]        rsrc2,
  output logic [6:0]        functR,
  output logic [DATA_W-1:0] imm_sext,
`ifdef DECODE_SCOREBOARD_EN
  output logic [DATA_W-1:0] imm_zext,
  input  logic              wb_valid,
  input  logic [4:0]        wb_idx
`else
  output logic [DATA_W-1:0] imm_zext
`endif
);

  logic          w_main_vld;
  logic [IW-1:0] w_main_ir;
  logic          w_stall;
  logic          w_down_rdy;
  dec_t          w_dec;

  skid_buf #(.W(IW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (in_ir),
    .o_valid (w_main_vld),
    .i_ready (w_down_rdy),
    .o_data  (w_main_ir)
  );

  assign w_dec      = decode_fields(w_main_ir[31:0]);
  assign opcode     = w_dec.opcode;
  assign rdst       = w_dec.rdst;
  assign rsrc1      = w_dec.rsrc1;
  assign rsrc2      = w_dec.rsrc2;
  assign functR     = w_dec.funct;
  assign imm_sext   = {{(DATA_W-16){w_dec.imm[15]}}, w_dec.imm};
  assign imm_zext   = {{(DATA_W-16){1'b0}}, w_dec.imm};
  assign out_valid  = w_main_vld & ~w_stall;
  assign w_down_rdy = out_ready & ~w_stall;

`ifdef DECODE_SCOREBOARD_EN
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_pend_eff;

  always_comb begin
    w_clr = '0;
    if (wb_valid) w_clr[wb_idx] = 1'b1;
  end

  // Writeback clear is bypassed so a retiring source releases the stall this cycle.
  assign w_pend_eff = r_pend & ~w_clr;
  assign w_stall    = w_pend_eff[w_dec.rsrc1] | w_pend_eff[w_dec.rsrc2];

  always_comb begin
    w_set = '0;
    if (out_valid && out_ready && !flush && (w_dec.rdst != 5'd0)) w_set[w_dec.rdst] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= (w_pend_eff | w_set) & {{(NREG-1){1'b1}}, 1'b0};
  end
`else
  assign w_stall = 1'b0;
`endif

endmodule
